// File: rtl/ps2_scan_sequencer.sv
// Pops bytes from the ps2_keyboard receiver FIFO, strips E0/F0 prefixes and queues one
// {code, ext, brk} event per make/break; also tracks the held key, a release count and overflow.
//
//  state  | meaning
//  IDLE   | wait for a byte and room in the event FIFO; latch rx_data
//  ACK    | one-cycle pop strobe; latched byte is decoded and pushed
//  SETTLE | dead cycle so rx_ready reflects the new receiver head
module ps2_scan_sequencer #(
    parameter int EVT_DEPTH       = 4,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_overflow,
    output logic       rx_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       key_held,
    output logic [7:0] held_code,
    output logic [7:0] release_count,
    output logic       err_overflow,
    input  logic       err_clr
);
    localparam int AW = $clog2(EVT_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(EVT_DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, SETTLE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     byte_q;
    logic           ext_flag, brk_flag, held_ext;
    logic [9:0]     fifo_mem [EVT_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           fifo_full, latch_byte, is_event, suppressed, do_push, do_pop;

    assign fifo_full = (count == CNT_FULL);
    assign evt_valid = (count != '0);
    assign do_pop    = evt_valid && evt_ready;
    assign {evt_code, evt_ext, evt_break} = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt     = state;
        latch_byte    = 1'b0;
        rx_nextdata_n = 1'b1;
        case (state)
            IDLE: begin
                if (rx_ready && !fifo_full) begin
                    latch_byte = 1'b1;
                    state_nxt  = ACK;
                end
            end
            ACK: begin
                rx_nextdata_n = 1'b0;
                state_nxt     = SETTLE;
            end
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Repeats only match a make of the same key while it is still held.
    always_comb begin
        is_event   = (state == ACK) && (byte_q != 8'h00) && (byte_q != 8'hE0) && (byte_q != 8'hF0);
        suppressed = SUPPRESS_REPEAT && !brk_flag && key_held &&
                     (byte_q == held_code) && (ext_flag == held_ext);
        do_push    = is_event && !suppressed;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            byte_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (latch_byte) byte_q <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else begin
            if (state == ACK) begin
                case (byte_q)
                    8'h00: ;
                    8'hE0: ext_flag <= 1'b1;
                    8'hF0: brk_flag <= 1'b1;
                    default: begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                endcase
            end
            if (rx_overflow) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_held      <= 1'b0;
            held_code     <= 8'h00;
            held_ext      <= 1'b0;
            release_count <= 8'h00;
            err_overflow  <= 1'b0;
        end else begin
            if (do_push) begin
                if (!brk_flag) begin
                    key_held  <= 1'b1;
                    held_code <= byte_q;
                    held_ext  <= ext_flag;
                end else begin
                    release_count <= release_count + 8'd1;
                    if (key_held && (byte_q == held_code) && (ext_flag == held_ext))
                        key_held <= 1'b0;
                end
            end
            if (err_clr)          err_overflow <= 1'b0;
            else if (rx_overflow) err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < EVT_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= {byte_q, ext_flag, brk_flag};
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: a queue-backed model of the ps2_keyboard FIFO feeds bytes, a
// scoreboard of expected events is filled as bytes are fed and drained as the DUT delivers.
module tb_ps2_scan_sequencer;
    logic       clk, clrn;
    logic [7:0] rx_data;
    logic       rx_ready, rx_overflow, rx_nextdata_n;
    logic       evt_valid, evt_ready, evt_ext, evt_break, key_held, err_overflow, err_clr;
    logic [7:0] evt_code, held_code, release_count;

    logic [7:0] nr_rx_data, nr_evt_code, nr_held_code, nr_release_count;
    logic       nr_rx_ready, nr_nextdata_n, nr_evt_valid, nr_evt_ext, nr_evt_break;
    logic       nr_key_held, nr_err_overflow;

    typedef struct {
        int         grp;
        logic [7:0] b;
        logic       ev;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] rxq[$], nrq[$];
    logic [9:0] sb[$];
    int         checks = 0, errors = 0;
    int         pops = 0, nr_events = 0, exp_rel = 0, pop_base = 0;
    logic       prev_low = 1'b0;

    ps2_scan_sequencer #(.EVT_DEPTH(4), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .key_held(key_held), .held_code(held_code), .release_count(release_count),
        .err_overflow(err_overflow), .err_clr(err_clr)
    );

    ps2_scan_sequencer #(.EVT_DEPTH(4), .SUPPRESS_REPEAT(1'b0)) dut_nr (
        .clk(clk), .clrn(clrn), .rx_data(nr_rx_data), .rx_ready(nr_rx_ready),
        .rx_overflow(1'b0), .rx_nextdata_n(nr_nextdata_n), .evt_valid(nr_evt_valid),
        .evt_ready(1'b1), .evt_code(nr_evt_code), .evt_ext(nr_evt_ext),
        .evt_break(nr_evt_break), .key_held(nr_key_held), .held_code(nr_held_code),
        .release_count(nr_release_count), .err_overflow(nr_err_overflow), .err_clr(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int g, input logic [7:0] b, input logic ev,
                                input logic [9:0] e);
        vec_t v;
        v.grp = g; v.b = b; v.ev = ev; v.exp = e;
        return v;
    endfunction

    task automatic refresh();
        rx_ready    = (rxq.size() != 0);
        rx_data     = rx_ready ? rxq[0] : 8'h00;
        nr_rx_ready = (nrq.size() != 0);
        nr_rx_data  = nr_rx_ready ? nrq[0] : 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic feed(input vec_t v, input logic to_nr);
        rxq.push_back(v.b);
        if (to_nr) nrq.push_back(v.b);
        if (v.ev) begin
            sb.push_back(v.exp);
            if (v.exp[0]) exp_rel = (exp_rel + 1) % 256;
        end
        refresh();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (n < max && !(rxq.size() == 0 && sb.size() == 0 && !evt_valid)) begin
            cyc(1);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout rxq=%0d sb=%0d", rxq.size(), sb.size());
        end
        cyc(4);
    endtask

    // Receiver model and event monitor, both away from the rising edge.
    always @(negedge clk) begin
        if (clrn && !rx_nextdata_n) begin
            checks++;
            if (prev_low) begin
                errors++;
                $display("FAIL pop_width actual=2+ cycles required=1");
            end
            pops++;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        prev_low = clrn && !rx_nextdata_n;
        if (clrn && !nr_nextdata_n && nrq.size() != 0) void'(nrq.pop_front());
        if (clrn && nr_evt_valid) nr_events++;
        if (clrn && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%0h required=none",
                         {evt_code, evt_ext, evt_break});
            end else begin
                check("event", {22'd0, evt_code, evt_ext, evt_break}, {22'd0, sb.pop_front()});
            end
        end
        refresh();
    end

    task automatic end_group(input int g);
        wait_idle(200);
        case (g)
            1: begin
                check("g1_key_held", key_held, 1);
                check("g1_held_code", held_code, 8'h1C);
            end
            2: begin
                check("g2_key_held", key_held, 0);
                check("g2_release_count", release_count, exp_rel);
                check("g2_pops", pops - pop_base, 3);
            end
            3: begin
                check("g3_key_held", key_held, 0);
                check("g3_release_count", release_count, exp_rel);
            end
            4: begin
                check("g4_key_held", key_held, 0);
                check("g4_release_count", release_count, exp_rel);
                check("g4_nr_events", nr_events, 4);
            end
            default: ;
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int p0;

        tbl.push_back(mk(1, 8'h1C, 1, {8'h1C, 1'b0, 1'b0}));
        tbl.push_back(mk(2, 8'hF0, 0, 10'h0));
        tbl.push_back(mk(2, 8'h1C, 1, {8'h1C, 1'b0, 1'b1}));
        tbl.push_back(mk(3, 8'hE0, 0, 10'h0));
        tbl.push_back(mk(3, 8'h75, 1, {8'h75, 1'b1, 1'b0}));
        tbl.push_back(mk(3, 8'hE0, 0, 10'h0));
        tbl.push_back(mk(3, 8'hF0, 0, 10'h0));
        tbl.push_back(mk(3, 8'h75, 1, {8'h75, 1'b1, 1'b1}));
        tbl.push_back(mk(4, 8'h1C, 1, {8'h1C, 1'b0, 1'b0}));
        tbl.push_back(mk(4, 8'h1C, 0, 10'h0));
        tbl.push_back(mk(4, 8'h1C, 0, 10'h0));
        tbl.push_back(mk(4, 8'hF0, 0, 10'h0));
        tbl.push_back(mk(4, 8'h1C, 1, {8'h1C, 1'b0, 1'b1}));

        clrn = 1'b0; rx_overflow = 1'b0; err_clr = 1'b0; evt_ready = 1'b1;
        refresh();
        cyc(3);
        check("rst_nextdata_n", rx_nextdata_n, 1);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_head", {evt_code, evt_ext, evt_break}, 0);
        check("rst_held", {key_held, held_code}, 0);
        check("rst_count_err", {release_count, err_overflow}, 0);
        clrn = 1'b1;
        cyc(2);

        pop_base = pops;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0 && tbl[i].grp != tbl[i-1].grp) end_group(tbl[i-1].grp);
            feed(tbl[i], tbl[i].grp == 4);
        end
        end_group(tbl[tbl.size()-1].grp);

        // Backpressure: four events fill the FIFO, the rest wait in the receiver.
        evt_ready = 1'b0;
        p0 = pops;
        feed(mk(5, 8'h15, 1, {8'h15, 2'b00}), 0);
        feed(mk(5, 8'h1D, 1, {8'h1D, 2'b00}), 0);
        feed(mk(5, 8'h24, 1, {8'h24, 2'b00}), 0);
        feed(mk(5, 8'h2D, 1, {8'h2D, 2'b00}), 0);
        feed(mk(5, 8'h2C, 1, {8'h2C, 2'b00}), 0);
        feed(mk(5, 8'h35, 1, {8'h35, 2'b00}), 0);
        cyc(40);
        check("bp_pops", pops - p0, 4);
        check("bp_rx_ready", rx_ready, 1);
        check("bp_nextdata_n", rx_nextdata_n, 1);
        check("bp_evt_valid", evt_valid, 1);
        for (int k = 0; k < 3; k++) begin
            check("bp_head_stable", {evt_code, evt_ext, evt_break}, {8'h15, 2'b00});
            cyc(1);
        end
        evt_ready = 1'b1;
        wait_idle(200);
        check("bp_held_code", {key_held, held_code}, {1'b1, 8'h35});

        // 256 press/release pairs wrap the release counter; a 00 byte inside a break prefix.
        for (int i = 0; i < 256; i++) begin
            c = 8'h10 + 8'(i & 63);
            feed(mk(6, c, 1, {c, 2'b00}), 0);
            feed(mk(6, 8'hF0, 0, 10'h0), 0);
            if (i == 100) feed(mk(6, 8'h00, 0, 10'h0), 0);
            feed(mk(6, c, 1, {c, 2'b01}), 0);
            if (i == 127) begin
                wait_idle(3000);
                check("wrap_mid_count", release_count, exp_rel);
            end
        end
        wait_idle(3000);
        check("wrap_count", release_count, exp_rel);
        check("wrap_count_abs", release_count, 8'd3);
        check("wrap_key_held", key_held, 0);

        // Overflow clears a pending F0, so the following code is a make.
        feed(mk(7, 8'hF0, 0, 10'h0), 0);
        wait_idle(50);
        rx_overflow = 1'b1; cyc(1); rx_overflow = 1'b0;
        check("ovf_set", err_overflow, 1);
        feed(mk(7, 8'h1C, 1, {8'h1C, 2'b00}), 0);
        wait_idle(50);
        check("ovf_make_held", {key_held, held_code}, {1'b1, 8'h1C});
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        check("ovf_clr", err_overflow, 0);
        rx_overflow = 1'b1; cyc(1); rx_overflow = 1'b0;
        check("ovf_set2", err_overflow, 1);
        rx_overflow = 1'b1; err_clr = 1'b1; cyc(1); rx_overflow = 1'b0; err_clr = 1'b0;
        check("ovf_clr_wins", err_overflow, 0);

        // Asynchronous reset while a byte is being acknowledged.
        evt_ready = 1'b0;
        feed(mk(8, 8'h33, 1, {8'h33, 2'b00}), 0);
        cyc(6);
        check("rst_pre_valid", evt_valid, 1);
        rx_overflow = 1'b1; cyc(1); rx_overflow = 1'b0;
        feed(mk(8, 8'h2A, 0, 10'h0), 0);
        for (int k = 0; k < 10 && rx_nextdata_n; k++) cyc(1);
        check("rst_reach_ack", rx_nextdata_n, 0);
        clrn = 1'b0;
        #1;
        check("arst_nextdata_n", rx_nextdata_n, 1);
        check("arst_evt_valid", evt_valid, 0);
        check("arst_evt_head", {evt_code, evt_ext, evt_break}, 0);
        check("arst_held", {key_held, held_code}, 0);
        check("arst_count_err", {release_count, err_overflow}, 0);
        rxq.delete();
        sb.delete();
        exp_rel = 0;
        refresh();
        p0 = pops;
        cyc(5);
        check("arst_no_pop", pops - p0, 0);
        clrn = 1'b1;
        evt_ready = 1'b1;
        cyc(10);
        check("post_rst_no_pop", pops - p0, 0);
        check("post_rst_valid", evt_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
